// File: rtl/udp_rx_ctrl.sv
// Packet-level controller for the UDP receive path: header parse, filter
// decision, payload forward/drop, close-reason reporting and packet statistics.
module udp_rx_ctrl #(
  parameter int NUM_PORTS   = 4,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 1024,
  parameter int PSEL_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_valid_in,
  input  logic                 packet_start,
  input  logic                 packet_last,
  input  logic                 header_done,
  input  logic [15:0]          udp_length,
  input  logic                 checksum_ok,
  input  logic [NUM_PORTS-1:0] port_hit,
  input  logic                 clr_stats,
  output logic                 parse_enable,
  output logic                 fwd_enable,
  output logic                 drop_enable,
  output logic [PSEL_W-1:0]    port_sel,
  output logic [CNT_W-1:0]     byte_count,
  output logic                 pkt_done,
  output logic [2:0]           pkt_status,
  output logic [CNT_W-1:0]     fwd_pkt_cnt,
  output logic [CNT_W-1:0]     drop_pkt_cnt,
  output logic [2:0]           state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PARSE = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_FWD   = 3'd3;
  localparam logic [2:0] S_DROP  = 3'd4;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_FILTERED = 3'd1;
  localparam logic [2:0] ST_CSUM_ERR = 3'd2;
  localparam logic [2:0] ST_LEN_ERR  = 3'd3;
  localparam logic [2:0] ST_TRUNC    = 3'd4;
  localparam logic [2:0] ST_TIMEOUT  = 3'd5;

  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  // Stream handshake: data_valid_in qualifies every beat and there is no
  // backpressure, so a beat is consumed on every cycle where valid is high.

  logic [2:0]           state, state_nxt;
  logic [15:0]          len_q;
  logic [NUM_PORTS-1:0] hit_q;
  logic                 csum_q;
  logic [TO_W-1:0]      idle_cnt;
  logic [PSEL_W-1:0]    hit_idx;
  logic [CNT_W:0]       cnt_incl;
  logic                 beat_last, start_beat, pass, len_ok, timeout_hit;
  logic                 close;
  logic [2:0]           close_status, fail_code;

  assign beat_last  = data_valid_in && packet_last;
  assign start_beat = (state == S_IDLE) && data_valid_in && packet_start;
  assign pass       = (|hit_q) && csum_q && (len_q >= 16'd8);
  assign fail_code  = !(|hit_q) ? ST_FILTERED : (!csum_q ? ST_CSUM_ERR : ST_LEN_ERR);

  // Length check counts the closing beat itself, one wider to avoid wrap.
  assign cnt_incl = {1'b0, byte_count} + (CNT_W+1)'(1);
  assign len_ok   = (cnt_incl == (CNT_W+1)'(len_q));

  assign timeout_hit = (TIMEOUT_CYC != 0) && (state != S_IDLE) && !data_valid_in &&
                       (idle_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    hit_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (hit_q[i]) hit_idx = PSEL_W'(i);
    end
  end

  always_comb begin
    state_nxt    = state;
    close        = 1'b0;
    close_status = ST_OK;
    case (state)
      S_IDLE: begin
        if (data_valid_in && packet_start) begin
          if (packet_last) begin
            close        = 1'b1;
            close_status = ST_TRUNC;
          end else begin
            state_nxt = S_PARSE;
          end
        end
      end
      S_PARSE: begin
        if (beat_last) begin
          close        = 1'b1;
          close_status = ST_TRUNC;
          state_nxt    = S_IDLE;
        end else if (header_done) begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (beat_last) begin
          close        = 1'b1;
          close_status = pass ? (len_ok ? ST_OK : ST_LEN_ERR) : fail_code;
          state_nxt    = S_IDLE;
        end else begin
          state_nxt = pass ? S_FWD : S_DROP;
        end
      end
      S_FWD: begin
        if (beat_last) begin
          close        = 1'b1;
          close_status = len_ok ? ST_OK : ST_LEN_ERR;
          state_nxt    = S_IDLE;
        end
      end
      S_DROP: begin
        if (beat_last) begin
          close        = 1'b1;
          close_status = fail_code;
          state_nxt    = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (timeout_hit) begin
      close        = 1'b1;
      close_status = ST_TIMEOUT;
      state_nxt    = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      len_q        <= '0;
      hit_q        <= '0;
      csum_q       <= 1'b0;
      idle_cnt     <= '0;
      port_sel     <= '0;
      byte_count   <= '0;
      pkt_done     <= 1'b0;
      pkt_status   <= '0;
      fwd_pkt_cnt  <= '0;
      drop_pkt_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pkt_done <= close;
      if (close) pkt_status <= close_status;

      // Header fields are captured with header_done and held through CHECK.
      if (state == S_PARSE && header_done && !beat_last) begin
        len_q  <= udp_length;
        hit_q  <= port_hit;
        csum_q <= checksum_ok;
      end
      if (state == S_CHECK) port_sel <= hit_idx;

      if (start_beat) begin
        byte_count <= CNT_W'(1);
      end else if (state != S_IDLE && data_valid_in && byte_count != '1) begin
        byte_count <= byte_count + CNT_W'(1);
      end

      if (state == S_IDLE || data_valid_in || timeout_hit) begin
        idle_cnt <= '0;
      end else if (TIMEOUT_CYC != 0) begin
        idle_cnt <= idle_cnt + TO_W'(1);
      end

      if (clr_stats) begin
        fwd_pkt_cnt  <= '0;
        drop_pkt_cnt <= '0;
      end else if (pkt_done) begin
        if (pkt_status == ST_OK) begin
          if (fwd_pkt_cnt != '1) fwd_pkt_cnt <= fwd_pkt_cnt + CNT_W'(1);
        end else begin
          if (drop_pkt_cnt != '1) drop_pkt_cnt <= drop_pkt_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign parse_enable = (state == S_PARSE) || start_beat;
  assign fwd_enable   = (state == S_FWD)  || (state == S_CHECK && pass);
  assign drop_enable  = (state == S_DROP) || (state == S_CHECK && !pass);
  assign state_dbg    = state;

endmodule

// File: tb/tb_udp_rx_ctrl.sv
// Bench for udp_rx_ctrl: directed and randomized packets checked against a
// packet-level reference model and an expected close-status queue.
module tb_udp_rx_ctrl;
  localparam int TO = 16;
  localparam logic [2:0] OK = 3'd0, FILT = 3'd1, CSUM = 3'd2, LENE = 3'd3, TRUNC = 3'd4, TOUT = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_valid_in, packet_start, packet_last, header_done;
  logic [15:0] udp_length;
  logic        checksum_ok;
  logic [3:0]  port_hit;
  logic        clr_stats;
  logic        parse_enable, fwd_enable, drop_enable;
  logic [1:0]  port_sel;
  logic [15:0] byte_count;
  logic        pkt_done;
  logic [2:0]  pkt_status;
  logic [15:0] fwd_pkt_cnt, drop_pkt_cnt;
  logic [2:0]  state_dbg;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [2:0]  exp_q[$];
  logic [15:0] exp_fwd = '0;
  logic [15:0] exp_drop = '0;

  // clock / reset block
  always #5 clk = ~clk;

  udp_rx_ctrl #(.NUM_PORTS(4), .CNT_W(16), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .data_valid_in(data_valid_in),
    .packet_start(packet_start), .packet_last(packet_last), .header_done(header_done),
    .udp_length(udp_length), .checksum_ok(checksum_ok), .port_hit(port_hit),
    .clr_stats(clr_stats), .parse_enable(parse_enable), .fwd_enable(fwd_enable),
    .drop_enable(drop_enable), .port_sel(port_sel), .byte_count(byte_count),
    .pkt_done(pkt_done), .pkt_status(pkt_status), .fwd_pkt_cnt(fwd_pkt_cnt),
    .drop_pkt_cnt(drop_pkt_cnt), .state_dbg(state_dbg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference model
  function automatic logic [2:0] ref_status(input int n, input int hb, input logic [3:0] hit,
                                            input logic cs, input logic [15:0] len);
    if (hb >= n) return TRUNC;
    if (hit == 4'd0) return FILT;
    if (!cs) return CSUM;
    if (len < 16'd8 || len != 16'(n)) return LENE;
    return OK;
  endfunction

  function automatic int lowest_bit(input logic [3:0] hit);
    for (int i = 0; i < 4; i++) if (hit[i]) return i;
    return 0;
  endfunction

  function automatic void account(input logic [2:0] st);
    if (st == OK) exp_fwd = (exp_fwd == 16'hFFFF) ? exp_fwd : exp_fwd + 16'd1;
    else exp_drop = (exp_drop == 16'hFFFF) ? exp_drop : exp_drop + 16'd1;
  endfunction

  // driver tasks
  task automatic drive(input logic v, input logic st, input logic ls, input logic hd);
    @(negedge clk);
    data_valid_in = v;
    packet_start  = st;
    packet_last   = ls;
    header_done   = hd;
  endtask

  task automatic chk_en(input string tag, input logic p, input logic f, input logic d);
    #1;
    chk({tag, "_parse"}, 32'(parse_enable), 32'(p));
    chk({tag, "_fwd"}, 32'(fwd_enable), 32'(f));
    chk({tag, "_drop"}, 32'(drop_enable), 32'(d));
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_fwd_cnt"}, 32'(fwd_pkt_cnt), 32'(exp_fwd));
    chk({tag, "_drop_cnt"}, 32'(drop_pkt_cnt), 32'(exp_drop));
  endtask

  // stop_at > 0 stalls after that beat and expects the idle timeout.
  task automatic send_pkt(input int n, input int hb, input logic [3:0] hit, input logic cs,
                          input logic [15:0] len, input int gap_max, input int stop_at,
                          input logic clr_at_done);
    logic [2:0] st;
    logic       pass, decided, hdr_drv;
    int         nb;
    pass    = (hit != 4'd0) && cs && (len >= 16'd8);
    decided = 1'b0;
    nb      = (stop_at > 0) ? stop_at : n;
    hdr_drv = (stop_at > 0) ? (hb <= stop_at) : (hb < n);
    st      = (stop_at > 0) ? TOUT : ref_status(n, hb, hit, cs, len);
    exp_q.push_back(st);
    udp_length  = len;
    checksum_ok = cs;
    port_hit    = hit;
    for (int i = 1; i <= nb; i++) begin
      int g;
      g = (i > 1) ? int'($urandom_range(0, gap_max)) : 0;
      for (int j = 0; j < g; j++) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk_en("gap", !decided, decided && pass, decided && !pass);
      end
      drive(1'b1, (i == 1) || ($urandom_range(0, 7) == 0), (i == n) && (stop_at == 0),
            hdr_drv && (i == hb));
      chk_en("beat", !decided, decided && pass, decided && !pass);
      if (hdr_drv && i == hb) decided = 1'b1;
    end
    if (stop_at > 0) begin
      for (int c = 0; c <= TO; c++) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("to_done", 32'(pkt_done), 32'(c == TO));
        chk("to_fwd", 32'(fwd_enable), 32'((c < TO) && pass));
      end
    end else begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      if (clr_at_done) clr_stats = 1'b1;
      #1 chk("done_pulse", 32'(pkt_done), 32'd1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    clr_stats = 1'b0;
    #1;
    if (clr_at_done) begin
      exp_fwd  = '0;
      exp_drop = '0;
    end else begin
      account(st);
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("idle_enables", 32'({parse_enable, fwd_enable, drop_enable}), 32'd0);
    chk("byte_count", 32'(byte_count), 32'(nb));
    chk("status_held", 32'(pkt_status), 32'(st));
    if (decided && hit != 4'd0) chk("port_sel", 32'(port_sel), 32'(lowest_bit(hit)));
    chk_stats("stats");
  endtask

  // scoreboard: every pkt_done pulse must match the next expected status
  always @(negedge clk) begin
    if (pkt_done) begin
      chk("done_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("pkt_status", 32'(pkt_status), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    data_valid_in = 0; packet_start = 0; packet_last = 0; header_done = 0;
    udp_length = '0; checksum_ok = 0; port_hit = '0; clr_stats = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_enables", 32'({parse_enable, fwd_enable, drop_enable}), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_done", 32'({pkt_done, pkt_status}), 32'd0);
    chk("rst_port_sel", 32'(port_sel), 32'd0);
    chk_stats("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // directed packets
    send_pkt(20, 8, 4'b0100, 1'b1, 16'd20, 0, 0, 1'b0);  // forwarded, port 2
    send_pkt(20, 8, 4'b0000, 1'b1, 16'd20, 0, 0, 1'b0);  // filtered
    send_pkt(20, 8, 4'b0100, 1'b0, 16'd20, 0, 0, 1'b0);  // checksum error
    send_pkt(20, 8, 4'b1010, 1'b1, 16'd20, 0, 0, 1'b0);  // lowest hit is 1
    send_pkt(20, 8, 4'b0100, 1'b1, 16'd24, 0, 0, 1'b0);  // short vs udp_length
    send_pkt(20, 8, 4'b0100, 1'b1, 16'd6,  0, 0, 1'b0);  // udp_length < 8
    send_pkt(5,  8, 4'b0100, 1'b1, 16'd20, 0, 0, 1'b0);  // truncated in parse
    send_pkt(1,  8, 4'b0100, 1'b1, 16'd20, 0, 0, 1'b0);  // start+last
    send_pkt(9,  8, 4'b0001, 1'b1, 16'd9,  0, 0, 1'b0);  // last beat in CHECK
    send_pkt(9,  8, 4'b0001, 1'b0, 16'd9,  0, 0, 1'b0);  // last in CHECK, drop
    send_pkt(8,  2, 4'b1000, 1'b1, 16'd8,  2, 0, 1'b0);  // minimum length, gaps
    send_pkt(20, 8, 4'b0100, 1'b1, 16'd20, 0, 12, 1'b0); // stall -> timeout
    send_pkt(20, 8, 4'b0010, 1'b1, 16'd20, 1, 0, 1'b0);  // accepted after timeout

    // reset mid-forward
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, i == 1, 1'b0, i == 8);
    end
    #1 chk("pre_rst_fwd", 32'(fwd_enable), 32'd1);
    @(negedge clk);
    data_valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_enables", 32'({parse_enable, fwd_enable, drop_enable}), 32'd0);
    chk("mid_rst_byte_count", 32'(byte_count), 32'd0);
    chk("mid_rst_port_sel", 32'(port_sel), 32'd0);
    chk("mid_rst_done", 32'({pkt_done, pkt_status}), 32'd0);
    exp_fwd = '0;
    exp_drop = '0;
    chk_stats("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_pkt(12, 4, 4'b0100, 1'b1, 16'd12, 0, 0, 1'b0);

    // saturation of the statistics counters
    @(negedge clk);
    force dut.fwd_pkt_cnt = 16'hFFFF;
    force dut.drop_pkt_cnt = 16'hFFFF;
    #1;
    release dut.fwd_pkt_cnt;
    release dut.drop_pkt_cnt;
    exp_fwd  = 16'hFFFF;
    exp_drop = 16'hFFFF;
    send_pkt(10, 3, 4'b0001, 1'b1, 16'd10, 0, 0, 1'b0);
    send_pkt(10, 3, 4'b0000, 1'b1, 16'd10, 0, 0, 1'b0);
    send_pkt(10, 3, 4'b0001, 1'b1, 16'd10, 0, 0, 1'b1);  // clear wins over done
    send_pkt(10, 3, 4'b0000, 1'b1, 16'd10, 0, 0, 1'b0);

    // randomized packets
    for (int k = 0; k < 30; k++) begin
      int n, hb, sel;
      logic [15:0] len;
      n   = $urandom_range(1, 30);
      hb  = $urandom_range(2, 10);
      sel = $urandom_range(0, 3);
      case (sel)
        0, 3:    len = 16'(n);
        1:       len = 16'(n + int'($urandom_range(1, 3)));
        default: len = 16'($urandom_range(0, 7));
      endcase
      send_pkt(n, hb, 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, len,
               $urandom_range(0, 3), 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
